// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier: one 32-bit adder reused over 32 iterations to form a 64-bit product.
// Optional two's-complement operands when SEQ_MULT_SIGNED_EN is defined (adds the FIX state).

module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// CALC  | one add/skip + shift iteration per clock, 32 iterations
// FIX   | (SEQ_MULT_SIGNED_EN only) negate the magnitude product if signs differ
// DONE  | product valid, done pulses for this single cycle
module seq_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  if (WIDTH != 32) begin : g_bad_width
    $error("seq_mult_ctrl: WIDTH must be 32 to match adder_32bit");
  end
  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
    $error("seq_mult_ctrl: CNT_W too narrow for WIDTH iterations");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
`ifdef SEQ_MULT_SIGNED_EN
    , S_FIX = 2'd3
`endif
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   add_s;
  logic               add_c;
  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH-1:0]   ld_mcand;
  logic [WIDTH-1:0]   ld_mq;
  logic               last_iter;

  adder_32bit u_add (
    .a    (acc_hi),
    .b    (mcand),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_c)
  );

  // The 65-bit {carry, sum, mq} shifted right by one; mq[0] itself drops out.
  assign shifted   = mq[0] ? {add_c, add_s, mq[WIDTH-1:1]}
                           : {1'b0, acc_hi, mq[WIDTH-1:1]};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
  logic sign;
  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign ld_mcand = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
  assign ld_mq    = multiplier[WIDTH-1]   ? -multiplier   : multiplier;
`else
  assign ld_mcand = multiplicand;
  assign ld_mq    = multiplier;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_CALC;
      S_CALC: begin
        if (last_iter) begin
`ifdef SEQ_MULT_SIGNED_EN
          state_nx = S_FIX;
`else
          state_nx = S_DONE;
`endif
        end
      end
`ifdef SEQ_MULT_SIGNED_EN
      S_FIX:  state_nx = S_DONE;
`endif
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi  <= '0;
      mq      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_hi <= '0;
            mq     <= ld_mq;
            mcand  <= ld_mcand;
            cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign   <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
`endif
          end
        end
        S_CALC: begin
          {acc_hi, mq} <= shifted;
          cnt          <= cnt + 1'b1;
`ifndef SEQ_MULT_SIGNED_EN
          if (last_iter) product <= shifted;
`endif
        end
`ifdef SEQ_MULT_SIGNED_EN
        S_FIX: begin
          product <= sign ? -{acc_hi, mq} : {acc_hi, mq};
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
